// File: rtl/hcp_pkg.sv
// Shared definitions for the HCP frame path: frame flag position, FSM state
// encodings, output port indices and the tagged delay-line stage record.
package hcp_pkg;

  // Bit of the 9-bit stream word that marks head and tail bytes.
  localparam int FRAME_FLAG_BIT = 8;

  // Width of the in-frame byte index; covers classification offsets up to 62.
  localparam int IDX_W = 6;

  // Frame classifier states (kept as plain 2-bit constants for legacy tools).
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLASSIFY = 2'd1;
  localparam logic [1:0] ST_PASS     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  // Output port indices.
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // One delay-line stage: byte plus the tags that decide where it goes.
  typedef struct packed {
    logic       valid;  // a byte occupies this stage
    logic       keep;   // byte belongs to a frame that will be forwarded
    logic       port;   // destination port (P0/P1), meaningful when keep=1
    logic [8:0] data;   // [8] frame flag, [7:0] byte
  } stage_t;

endpackage

// File: rtl/frame_demux_if.sv
// Byte-stream bus: 9-bit word ([8] frame flag) with a single valid strobe.
// The master drives the word, the slave consumes it; there is no backpressure.
interface frame_demux_if;
  logic [8:0] data;
  logic       wr;

  modport master (output data, output wr);
  modport slave  (input  data, input  wr);
endinterface

// File: rtl/frame_delay_line.sv
// Tagged shift register that holds frame bytes while the classifier decides
// their destination. Every cycle each stage moves one place down the line.
// tag_wr stamps keep=1/port=tag_port onto every byte shifting out of stages
// 0..DEPTH-2 (the bytes of the frame being classified); force_flag sets the
// frame flag on the byte leaving stage 0 so a cut frame appears terminated.
module frame_delay_line
  import hcp_pkg::*;
#(
  parameter int DEPTH = 15
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  stage_t in_stage,
  input  logic   tag_wr,
  input  logic   tag_port,
  input  logic   force_flag,
  output stage_t out_stage
);

  stage_t line_q [DEPTH];
  stage_t line_d [DEPTH];

  // Next-state of the line: plain shift with optional bulk tag write and flag force.
  // NOTE: every element gets a value on every path before any conditional
  // override, so no latch is inferred; blocking '=' here, '<=' only in always_ff.
  always_comb begin
    line_d[0] = in_stage;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
      if (tag_wr) begin
        line_d[i].keep = 1'b1;
        line_d[i].port = tag_port;
      end
    end
    if (force_flag) begin
      line_d[1].data[FRAME_FLAG_BIT] = 1'b1;
    end
  end

  // Stage registers.
  // NOTE: the whole line is reset, not just a pointer: stale valid/keep tags
  // left over from before reset would otherwise be forwarded as frame bytes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= line_d[i];
      end
    end
  end

  assign out_stage = line_q[DEPTH-1];

endmodule

// File: rtl/frame_demux.sv
// 1-to-2 frame dispatcher. Each frame is classified by its byte at SEL_OFFSET:
// a match with SEL_VALUE sends it to port 0, anything else to port 1. Bytes wait
// in a SEL_OFFSET+1 stage delay line until the decision is made, so the whole
// frame (head included) can be steered. Short or gapped frames are flagged on
// o_frame_err; frames that never reached classification are counted as drops.
// A byte presented in cycle t leaves on its port in cycle t+SEL_OFFSET+2.
module frame_demux
  import hcp_pkg::*;
#(
  parameter int         SEL_OFFSET = 14,
  parameter logic [7:0] SEL_VALUE  = 8'h05
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  frame_demux_if.slave         in_bus,
  frame_demux_if.master        p0_bus,
  frame_demux_if.master        p1_bus,
  output logic                 o_frame_err,
  output logic [15:0]          ov_drop_cnt
);

  localparam int                DEPTH   = SEL_OFFSET + 1;
  localparam logic [IDX_W-1:0]  SEL_IDX = IDX_W'(SEL_OFFSET);

  // Classifier state.
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;     // index of the last accepted byte of the frame
  logic             route_q, route_d; // port latched at classification
  logic [15:0]      drop_cnt;

  // Per-cycle controls for the delay line and event counters.
  stage_t           in_stage;
  stage_t           last_stage;
  logic             in_keep;
  logic             in_port;
  logic             tag_wr;
  logic             force_flag;
  logic             err_ev;
  logic             drop_ev;

  // Decoded input.
  logic             in_flag;
  logic             sel_route;
  logic [IDX_W-1:0] cur_idx;

  assign in_flag   = in_bus.data[FRAME_FLAG_BIT];
  assign sel_route = (in_bus.data[7:0] == SEL_VALUE) ? P0 : P1;
  assign cur_idx   = idx_q + IDX_W'(1);

  // Frame classifier: decides tags for the incoming byte and the line contents.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    route_d    = route_q;
    in_keep    = 1'b0;
    in_port    = route_q;
    tag_wr     = 1'b0;
    force_flag = 1'b0;
    err_ev     = 1'b0;
    drop_ev    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A flagged byte opens a frame; an unflagged one is a stray and is discarded.
        if (in_bus.wr && in_flag) begin
          state_d = ST_CLASSIFY;
          idx_d   = '0;
        end
      end

      ST_CLASSIFY: begin
        if (!in_bus.wr) begin
          // Frame broke before it could be classified: nothing of it was sent.
          err_ev  = 1'b1;
          drop_ev = 1'b1;
          state_d = ST_DROP;
        end else if (cur_idx == SEL_IDX) begin
          // Classification byte: steer it and every earlier byte of the frame.
          route_d = sel_route;
          in_keep = 1'b1;
          in_port = sel_route;
          tag_wr  = 1'b1;
          idx_d   = cur_idx;
          state_d = in_flag ? ST_IDLE : ST_PASS;
        end else if (in_flag) begin
          // Tail arrived before the classification byte: short frame.
          err_ev  = 1'b1;
          drop_ev = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = cur_idx;
        end
      end

      ST_PASS: begin
        if (!in_bus.wr) begin
          // Part of the frame is already committed; close it off on the last
          // accepted byte and discard the rest. Not a drop, only an error.
          force_flag = 1'b1;
          err_ev     = 1'b1;
          state_d    = ST_DROP;
        end else begin
          in_keep = 1'b1;
          in_port = route_q;
          if (in_flag) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        // The next flagged byte is the broken frame's own tail.
        if (in_bus.wr && in_flag) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_stage.valid = in_bus.wr;
    in_stage.keep  = in_bus.wr & in_keep;
    in_stage.port  = in_port;
    in_stage.data  = in_bus.wr ? in_bus.data : '0;
  end

  frame_delay_line #(
    .DEPTH (DEPTH)
  ) u_delay_line (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .in_stage   (in_stage),
    .tag_wr     (tag_wr),
    .tag_port   (route_d),
    .force_flag (force_flag),
    .out_stage  (last_stage)
  );

  // Classifier registers, error pulse and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      route_q     <= P0;
      o_frame_err <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      route_q     <= route_d;
      o_frame_err <= err_ev;
      if (drop_ev && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign ov_drop_cnt = drop_cnt;

  logic fwd_p0;
  logic fwd_p1;
  assign fwd_p0 = last_stage.valid & last_stage.keep & (last_stage.port == P0);
  assign fwd_p1 = last_stage.valid & last_stage.keep & (last_stage.port == P1);

  // Registered output stage: the last delay stage goes to exactly one port or none.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p0_bus.data <= '0;
      p0_bus.wr   <= 1'b0;
      p1_bus.data <= '0;
      p1_bus.wr   <= 1'b0;
    end else begin
      p0_bus.data <= fwd_p0 ? last_stage.data : '0;
      p0_bus.wr   <= fwd_p0;
      p1_bus.data <= fwd_p1 ? last_stage.data : '0;
      p1_bus.wr   <= fwd_p1;
    end
  end

endmodule

// File: tb/tb_frame_demux.sv
// Self-checking bench for frame_demux. Stimulus is a per-cycle plan built from
// frame descriptions; the expected port, data, error pulse and drop count of
// every cycle are derived from each frame's fate (forwarded, cut, short,
// dropped) and the fixed latency, then compared cycle by cycle.
module tb_frame_demux;
  import hcp_pkg::*;

  localparam int         SEL_OFFSET = 14;
  localparam logic [7:0] SEL_VALUE  = 8'h05;
  localparam int         OUT_DELAY  = SEL_OFFSET + 1; // cycles from drive to visible output after the edge

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_frame_err;
  logic [15:0] ov_drop_cnt;

  frame_demux_if in_bus ();
  frame_demux_if p0_bus ();
  frame_demux_if p1_bus ();

  frame_demux #(
    .SEL_OFFSET (SEL_OFFSET),
    .SEL_VALUE  (SEL_VALUE)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .in_bus      (in_bus),
    .p0_bus      (p0_bus),
    .p1_bus      (p1_bus),
    .o_frame_err (o_frame_err),
    .ov_drop_cnt (ov_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle plan: input word plus what that cycle must produce.
  logic        q_wr   [$];
  logic [8:0]  q_data [$];
  int          q_dst  [$];   // 0 none, 1 port 0, 2 port 1
  logic [8:0]  q_out  [$];   // word expected on the destination port
  logic        q_err  [$];   // error pulse expected right after this cycle's edge
  logic [15:0] q_drop [$];   // drop count expected right after this cycle's edge
  logic [15:0] m_drop;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_plan();
    q_wr.delete(); q_data.delete(); q_dst.delete();
    q_out.delete(); q_err.delete(); q_drop.delete();
  endtask

  task automatic push(input logic wr, input logic [8:0] d, input int dst,
                      input logic [8:0] od, input logic err, input logic drop);
    if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    q_wr.push_back(wr);   q_data.push_back(d);  q_dst.push_back(dst);
    q_out.push_back(od);  q_err.push_back(err); q_drop.push_back(m_drop);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 9'h0, 0, 9'h0, 1'b0, 1'b0);
  endtask

  task automatic add_stray();
    push(1'b1, {1'b0, 8'($urandom)}, 0, 9'h0, 1'b0, 1'b0);
  endtask

  // One frame of len bytes; gap_at = index of the byte preceded by gap_len idle
  // cycles (-1 for none); has_tail=0 leaves the frame open (used before a reset).
  task automatic add_frame(input int len, input logic [7:0] sel, input int gap_at,
                           input int gap_len, input int idle_after, input bit has_tail);
    bit gap_drop, short_f, pass_gap, fwd, flag;
    int dst;
    logic [7:0] b;
    gap_drop = (gap_at >= 1) && (gap_at <= SEL_OFFSET) && (gap_at < len);
    pass_gap = (gap_at > SEL_OFFSET) && (gap_at < len);
    short_f  = !gap_drop && has_tail && (len <= SEL_OFFSET);
    dst      = (gap_drop || short_f) ? 0 : ((sel == SEL_VALUE) ? 1 : 2);
    for (int i = 0; i < len; i++) begin
      if (i == gap_at && (gap_drop || pass_gap)) begin
        for (int g = 0; g < gap_len; g++)
          push(1'b0, 9'h0, 0, 9'h0, g == 0, (g == 0) && gap_drop);
      end
      b    = (i == SEL_OFFSET) ? sel : 8'($urandom);
      flag = (i == 0) || (has_tail && i == len - 1);
      fwd  = (dst != 0) && !(pass_gap && i >= gap_at);
      push(1'b1, {flag, b}, fwd ? dst : 0,
           {flag || (pass_gap && i == gap_at - 1), b},
           short_f && (i == len - 1), short_f && (i == len - 1));
    end
    add_idle(idle_after);
  endtask

  // Drive the plan one word per cycle; check outputs 1 time unit after each edge.
  task automatic run_plan(input string name);
    logic [15:0] e0, e1;
    int m;
    for (int n = 0; n < q_wr.size(); n++) begin
      in_bus.wr   = q_wr[n];
      in_bus.data = q_data[n];
      @(posedge i_clk);
      #1;
      e0 = 16'h0;
      e1 = 16'h0;
      if (n >= OUT_DELAY) begin
        m = n - OUT_DELAY;
        if (q_dst[m] == 1) e0 = 16'({1'b1, q_out[m]});
        if (q_dst[m] == 2) e1 = 16'({1'b1, q_out[m]});
      end
      check($sformatf("%s_p0_c%0d", name, n), 16'({p0_bus.wr, p0_bus.data}), e0);
      check($sformatf("%s_p1_c%0d", name, n), 16'({p1_bus.wr, p1_bus.data}), e1);
      check($sformatf("%s_err_c%0d", name, n), 16'(o_frame_err), 16'(q_err[n]));
      check($sformatf("%s_drop_c%0d", name, n), ov_drop_cnt, q_drop[n]);
    end
    in_bus.wr   = 1'b0;
    in_bus.data = 9'h0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_p0"}, 16'({p0_bus.wr, p0_bus.data}), 16'h0);
    check({name, "_p1"}, 16'({p1_bus.wr, p1_bus.data}), 16'h0);
    check({name, "_err"}, 16'(o_frame_err), 16'h0);
    check({name, "_drop"}, ov_drop_cnt, 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, gap_at;
    logic [7:0] sel;

    // Reset state.
    i_rst_n     = 1'b0;
    in_bus.wr   = 1'b0;
    in_bus.data = 9'h0;
    #1;
    check_quiet("reset");
    repeat (3) @(posedge i_clk);
    #1;
    check_quiet("reset_hold");
    i_rst_n = 1'b1;

    // Directed frames followed by a randomized mix, as one continuous stream.
    clear_plan();
    m_drop = 16'h0;
    add_frame(64, SEL_VALUE, -1, 0, 3, 1'b1);   // plain port-0 frame
    add_frame(64, 8'h22, -1, 0, 0, 1'b1);       // port 1, then back-to-back port 0
    add_frame(60, SEL_VALUE, -1, 0, 2, 1'b1);
    add_frame(10, SEL_VALUE, -1, 0, 2, 1'b1);   // short frame
    add_frame(64, SEL_VALUE, 30, 3, 2, 1'b1);   // gap after classification
    add_frame(40, 8'h22, 7, 2, 1, 1'b1);        // gap before classification
    add_frame(15, SEL_VALUE, -1, 0, 0, 1'b1);   // exact minimum length
    add_frame(15, 8'h71, -1, 0, 0, 1'b1);
    add_stray();
    add_stray();
    add_frame(16, SEL_VALUE, 15, 1, 1, 1'b1);   // gap right after the classification byte
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(3) == 0) len = 2 + $urandom_range(13);
      else                        len = 15 + $urandom_range(65);
      sel = ($urandom_range(1) == 0) ? SEL_VALUE : 8'($urandom);
      if (f % 2 == 0 && sel == SEL_VALUE) sel = 8'h33;
      gap_at = ($urandom_range(3) == 0) ? 1 + $urandom_range(len - 2) : -1;
      add_frame(len, sel, gap_at, 1 + $urandom_range(2), $urandom_range(3), 1'b1);
      if ($urandom_range(4) == 0) add_stray();
    end
    add_idle(20);
    run_plan("stream");

    // Reset in the middle of a frame (reset asserted after index 20).
    clear_plan();
    add_frame(21, SEL_VALUE, -1, 0, 0, 1'b0);
    run_plan("partial");
    i_rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    repeat (2) @(posedge i_clk);
    #1;
    check_quiet("midreset_hold");
    i_rst_n = 1'b1;
    clear_plan();
    m_drop = 16'h0;
    add_frame(64, SEL_VALUE, -1, 0, 2, 1'b1);
    add_frame(30, 8'h44, -1, 0, 20, 1'b1);
    run_plan("after_reset");

    // Saturation: preload the counter near its limit, then a burst of short frames.
    clear_plan();
    m_drop = 16'hFFFD;
    for (int f = 0; f < 4; f++) add_frame(2 + $urandom_range(12), SEL_VALUE, -1, 0, $urandom_range(1), 1'b1);
    add_frame(20, SEL_VALUE, -1, 0, 20, 1'b1);
    force dut.drop_cnt = 16'hFFFD;
    @(posedge i_clk);
    #1;
    release dut.drop_cnt;
    check("sat_preload", ov_drop_cnt, 16'hFFFD);
    run_plan("saturate");
    check("sat_final", ov_drop_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
